// File: rtl/fifo_port_arb.sv
// fifo_port_arb: arbitrates a write producer and a read consumer onto one
// half-duplex FIFO port, with burst fairness and a bus turnaround cycle.
module fifo_port_arb #(
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       rd_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       fifo_en,
    output logic       fifo_rw,
    output logic [7:0] fifo_wdata,
    output logic       fifo_oe,
    input  logic [7:0] fifo_rdata,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    output logic       err
);
    localparam int   CW     = $clog2(DEPTH) + 1;
    localparam int   BW     = $clog2(MAX_BURST + 1);
    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    typedef enum logic [1:0] {IDLE, WR, RD, TURN} state_t;
    typedef struct packed {
        logic vld;
        logic dir;
        logic turn;
    } grant_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_nxt;
    logic [BW-1:0] burst;
    logic          dir;
    logic          fresh;
    logic          wr_el;
    logic          rd_el;
    grant_t        gnt;

    // Eligibility uses the count as it stands after this edge, so back-to-back
    // grants never overrun either end of the FIFO.
    always_comb begin
        cnt_nxt = count;
        if (state == WR)
            cnt_nxt = count + CW'(1);
        else if (state == RD)
            cnt_nxt = count - CW'(1);
    end

    assign wr_el = wr_req && (cnt_nxt < CW'(DEPTH));
    assign rd_el = rd_req && (cnt_nxt != '0);

    // No access since reset means the bus has no history: no turnaround and
    // a contested first grant goes to the writer.
    always_comb begin
        gnt.vld = wr_el || rd_el;
        gnt.dir = wr_el ? DIR_WR : DIR_RD;
        if (wr_el && rd_el && !fresh)
            gnt.dir = (burst == BW'(MAX_BURST)) ? ~dir : dir;
        gnt.turn = gnt.vld && !fresh && (gnt.dir != dir);
    end

    // wr_ack is high in the cycle whose fifo_wdata holds the producer's word;
    // the producer presents its next word before that cycle's closing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            burst      <= '0;
            dir        <= DIR_RD;
            fresh      <= 1'b1;
            fifo_en    <= 1'b0;
            fifo_rw    <= 1'b0;
            fifo_oe    <= 1'b0;
            fifo_wdata <= 8'h00;
            wr_ack     <= 1'b0;
            rd_data    <= 8'h00;
            rd_valid   <= 1'b0;
            err        <= 1'b0;
        end else begin
            count    <= cnt_nxt;
            fifo_en  <= 1'b0;
            fifo_oe  <= 1'b0;
            wr_ack   <= 1'b0;
            rd_valid <= 1'b0;

            if (state == RD) begin
                rd_data  <= fifo_rdata;
                rd_valid <= 1'b1;
            end

            if ((fifo_full && (count != CW'(DEPTH))) || (fifo_empty && (count != '0)))
                err <= 1'b1;

            if (!gnt.vld) begin
                state <= IDLE;
            end else if (gnt.turn) begin
                // Turnaround claims the new direction; the grant itself is
                // re-decided when TURN ends.
                state <= TURN;
                dir   <= gnt.dir;
                burst <= '0;
            end else begin
                state   <= gnt.dir ? WR : RD;
                dir     <= gnt.dir;
                fresh   <= 1'b0;
                burst   <= (burst == BW'(MAX_BURST)) ? burst : burst + BW'(1);
                fifo_en <= 1'b1;
                fifo_rw <= gnt.dir;
                fifo_oe <= gnt.dir;
                wr_ack  <= gnt.dir;
                if (gnt.dir)
                    fifo_wdata <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_fifo_port_arb.sv
// Directed bench for fifo_port_arb with a behavioural 8-deep FIFO on the port
// and a word scoreboard between producer and consumer.
module tb_fifo_port_arb;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_req, rd_req, wr_ack, rd_valid;
    logic       fifo_en, fifo_rw, fifo_oe, fifo_full, fifo_empty, err;
    logic [7:0] wr_data, rd_data, fifo_wdata, fifo_rdata;
    logic       force_empty;

    logic [7:0] mem [8];
    int         n, wp, rp;
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         failures = 0;
    int         wr_left, ack_cnt, rd_cnt;
    logic [7:0] wr_step;
    logic [7:0] exp_w;
    logic [7:0] obs_c;
    string      pat;

    always #5 clk = ~clk;

    fifo_port_arb #(.DEPTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_en(fifo_en), .fifo_rw(fifo_rw), .fifo_wdata(fifo_wdata),
        .fifo_oe(fifo_oe), .fifo_rdata(fifo_rdata),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .err(err)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n  <= 0;
            wp <= 0;
            rp <= 0;
        end else if (fifo_en && fifo_rw && n < 8) begin
            mem[wp] <= fifo_wdata;
            wp      <= (wp + 1) % 8;
            n       <= n + 1;
        end else if (fifo_en && !fifo_rw && n > 0) begin
            rp <= (rp + 1) % 8;
            n  <= n - 1;
        end
    end

    assign fifo_rdata = mem[rp];
    assign fifo_full  = (n == 8);
    assign fifo_empty = force_empty || (n == 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at negedge, score reads, advance the producer on ack.
    task automatic tick();
        @(negedge clk);
        chk("cnt_range", 32'(n <= 8), 1);
        if (fifo_en && !fifo_rw)
            chk("rd_nonempty", 32'(n > 0), 1);
        if (rd_valid) begin
            rd_cnt++;
            chk("rd_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0)
                chk("rd_data", rd_data, exp_q.pop_front());
        end
        if (wr_ack) begin
            ack_cnt++;
            exp_q.push_back(wr_data);
            if (wr_left > 1) begin
                wr_left--;
                wr_data = wr_data + wr_step;
            end else begin
                wr_left = 0;
                wr_req  = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
        force_empty = 1'b0; wr_left = 0; wr_step = 8'h00; ack_cnt = 0; rd_cnt = 0;
        repeat (2) @(negedge clk);
        chk("rst_en", fifo_en, 0);
        chk("rst_rw", fifo_rw, 0);
        chk("rst_oe", fifo_oe, 0);
        chk("rst_ack", wr_ack, 0);
        chk("rst_rv", rd_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_wdata", fifo_wdata, 8'h00);
        chk("rst_rdata", rd_data, 8'h00);

        // Fill: first grant on the first edge after reset, 8 consecutive acks.
        reset = 1'b0;
        wr_req = 1'b1; wr_data = 8'h11; wr_left = 9; wr_step = 8'h11;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_w = 8'(8'h11 * (i + 1));
            chk("fill_ack", wr_ack, 1);
            chk("fill_oe", fifo_oe, 1);
            chk("fill_wdata", fifo_wdata, exp_w);
        end
        repeat (2) begin
            tick();
            chk("full_noack", wr_ack, 0);
            chk("full_noen", fifo_en, 0);
        end
        chk("full_flag", fifo_full, 1);
        chk("full_err", err, 0);

        // Drain: one turnaround then 8 in-order reads.
        wr_req = 1'b0; wr_left = 0; rd_req = 1'b1; rd_cnt = 0;
        tick();
        chk("drain_turn", fifo_en, 0);
        tick();
        chk("drain_en", fifo_en, 1);
        chk("drain_rw", fifo_rw, 0);
        chk("drain_oe", fifo_oe, 0);
        repeat (10) tick();
        chk("drain_cnt", rd_cnt, 8);
        chk("drain_sb", exp_q.size(), 0);
        chk("drain_empty", fifo_empty, 1);
        chk("drain_idle", fifo_en, 0);
        rd_req = 1'b0;

        // Two words stored, then both sides contend.
        ack_cnt = 0;
        wr_req = 1'b1; wr_data = 8'hA1; wr_left = 2; wr_step = 8'h01;
        repeat (4) tick();
        chk("pre_acks", ack_cnt, 2);
        pat = "WW-RRRR-WWWW-RRRR-";
        wr_req = 1'b1; wr_data = 8'hB1; wr_left = 1000; rd_req = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            obs_c = fifo_en ? (fifo_rw ? 8'h57 : 8'h52) : 8'h2D;
            chk("burst_pat", obs_c, pat[i]);
        end
        wr_req = 1'b0; wr_left = 0;
        repeat (10) tick();
        chk("burst_sb", exp_q.size(), 0);
        chk("burst_empty", fifo_empty, 1);
        chk("burst_err", err, 0);
        rd_req = 1'b0;

        // Reset lands in the fourth write (count=3).
        ack_cnt = 0;
        wr_req = 1'b1; wr_data = 8'hC1; wr_left = 10;
        for (int i = 0; i < 12 && ack_cnt < 4; i++) tick();
        chk("pre_rst_wr", wr_ack, 1);
        reset = 1'b1; wr_req = 1'b0; wr_left = 0;
        #1;
        chk("midrst_en", fifo_en, 0);
        chk("midrst_ack", wr_ack, 0);
        chk("midrst_oe", fifo_oe, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0; rd_req = 1'b1;
        repeat (3) begin
            tick();
            chk("postrst_noread", fifo_en, 0);
            chk("postrst_norv", rd_valid, 0);
        end
        chk("postrst_wdata", fifo_wdata, 8'h00);
        chk("postrst_err", err, 0);

        // Fresh after reset: write granted with no turnaround.
        rd_req = 1'b0; wr_req = 1'b1; wr_data = 8'hD1; wr_left = 2;
        tick();
        chk("fresh_en", fifo_en, 1);
        chk("fresh_rw", fifo_rw, 1);
        chk("fresh_wdata", fifo_wdata, 8'hD1);
        repeat (2) tick();
        chk("two_stored", n, 2);
        chk("pre_force_err", err, 0);

        // Empty flag disagrees with count=2.
        force_empty = 1'b1;
        tick();
        chk("err_set", err, 1);
        force_empty = 1'b0;
        repeat (3) tick();
        chk("err_sticky", err, 1);
        reset = 1'b1;
        #1;
        chk("err_clr", err, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_port_arb.md
FIFO_PORT_ARB -- requirements
Module: fifo_port_arb

Interface
REQ-001 Parameter DEPTH, default 8: FIFO word capacity; occupancy counter width is clog2(DEPTH)+1.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive same-direction grants while the opposite requester is eligible.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; same net drives the FIFO reset.
REQ-005 wr_req  input  1  producer holds a valid word on wr_data.
REQ-006 wr_data  input  8  producer word; stable while wr_req=1 until wr_ack.
REQ-007 wr_ack  output  1  one-cycle pulse: word consumed; producer advances on the following edge.
REQ-008 rd_req  input  1  consumer can accept a word.
REQ-009 rd_data  output  8  registered read word.
REQ-010 rd_valid  output  1  one-cycle pulse: rd_data holds a new word.
REQ-011 fifo_en  output  1  FIFO enable.
REQ-012 fifo_rw  output  1  FIFO direction: 1=write, 0=read.
REQ-013 fifo_wdata  output  8  word driven onto FIFO io.
REQ-014 fifo_oe  output  1  enables the external io tristate driver of fifo_wdata.
REQ-015 fifo_rdata  input  8  FIFO io bus as sampled.
REQ-016 fifo_full, fifo_empty  input  1 each  FIFO status flags.
REQ-017 err  output  1  sticky occupancy-mismatch flag.

Function
REQ-018 States SHALL be IDLE, WR, RD, TURN; every state lasts exactly one cycle; all outputs are registered.
REQ-019 In WR: fifo_en=1, fifo_rw=1, fifo_oe=1, wr_ack=1; in RD: fifo_en=1, fifo_rw=0, fifo_oe=0; in IDLE/TURN: fifo_en=0, fifo_oe=0, wr_ack=0.
REQ-020 A write SHALL be eligible when wr_req=1 and count<DEPTH; a read when rd_req=1 and count>0.
REQ-021 Internal count SHALL increment at the end of each WR cycle, decrement at the end of each RD cycle, and never exceed the range 0..DEPTH.
REQ-022 Eligibility SHALL use the internal count, not fifo_full/fifo_empty, so back-to-back grants are correct.
REQ-023 fifo_wdata SHALL capture wr_data on the edge entering WR and hold it through that cycle.
REQ-024 rd_data SHALL capture fifo_rdata on the edge ending an RD cycle; rd_valid=1 for the following cycle only.
REQ-025 Decision at each edge: only one direction eligible -> grant it; neither -> IDLE.
REQ-026 Both eligible -> continue the last-granted direction unless burst count = MAX_BURST, then switch.
REQ-027 Burst count SHALL reset to 1 on a direction change and saturate at MAX_BURST.
REQ-028 last direction after reset = read, so the first contested grant goes to write.
REQ-029 A grant whose direction differs from the last access SHALL pass through one TURN cycle first; the decision is re-evaluated at the end of TURN.
REQ-030 The TURN rule SHALL apply even when IDLE cycles separate the two accesses.
REQ-031 Max throughput: one word per cycle in a same-direction run.
REQ-032 err SHALL set when fifo_full=1 with count!=DEPTH, or fifo_empty=1 with count!=0, in any cycle; only reset clears err.

Reset
REQ-033 While reset=1 (asynchronous): state=IDLE; fifo_en, fifo_rw, fifo_oe, wr_ack, rd_valid, err = 0; count=0; burst count=0; last direction = read.
REQ-034 rd_data and fifo_wdata SHALL reset to 8'h00.
REQ-035 Reset asserted during WR/RD SHALL deassert fifo_en immediately; the access is discarded and wr_ack/rd_valid is not issued.
REQ-036 First grant possible on the first edge after reset deasserts.

Verification
REQ-037 Write 8 words 0x11..0x88 with rd_req=0 -> 8 consecutive wr_ack; count=8; fifo_full=1; 9th wr_req held with no ack; err=0.
REQ-038 Then rd_req=1 -> one TURN cycle, then 8 RD cycles; rd_valid words 0x11..0x88 in order; fifo_empty=1; no read while empty.
REQ-039 With 2 words stored, wr_req and rd_req both held -> grants run in MAX_BURST=4 bursts separated by TURN; count never leaves 0..8.
REQ-040 Reset pulse mid-WR at count=3 -> fifo_en=0 that cycle; no wr_ack; count=0; a following read is not granted.
REQ-041 Force fifo_empty=1 while count=2 -> err=1 next cycle and remains 1 until reset.
